// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one sram-like memory port between the instruction requester (IF)
//   and the data requester (EXE/MEM). Data normally wins, but an instruction
//   fetch that has lost STARVE_MAX times in a row is forced through. Once a
//   request is presented downstream it is held (locked) until accepted. An
//   in-order tag FIFO remembers who issued each outstanding request, so every
//   m_data_ok is steered back to the right requester.
//
// Ports
//   clk, reset                       clock, async active-high reset
//   inst_req/wr/size/addr/wdata      instruction-side request
//   inst_addr_ok/data_ok/rdata       instruction-side handshake + response
//   data_req/wr/size/addr/wdata      data-side request
//   data_addr_ok/data_ok/rdata       data-side handshake + response
//   m_req/wr/size/addr/wdata         downstream request
//   m_addr_ok, m_data_ok, m_rdata    downstream handshake + response
//   arb_err                          sticky: response seen with no request outstanding
module sram_like_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned STARVE_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        arb_err
);

    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    owner_t          fifo_owner [OUTSTANDING];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            lock;
    owner_t          lock_owner;
    logic [SW-1:0]   starve_cnt;

    owner_t          winner;
    logic            win_req;
    logic            fifo_empty;
    logic            push_blocked;
    logic            push;
    logic            pop;
    owner_t          head_owner;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        winner = OWN_INST;
        if (lock)
            winner = lock_owner;
        else if (starve_cnt == SW'(STARVE_MAX) && inst_req)
            winner = OWN_INST;
        else if (data_req)
            winner = OWN_DATA;
    end

    assign fifo_empty = (count == '0);
    assign pop        = m_data_ok & ~fifo_empty;
    assign head_owner = fifo_owner[rd_ptr];

    // A full FIFO still accepts an issue in the same cycle a response frees a
    // slot, so push+pop at full keeps the pipe streaming.
    assign push_blocked = (count == CW'(OUTSTANDING)) & ~pop;

    assign win_req = (winner == OWN_DATA) ? data_req : inst_req;
    assign m_req   = win_req & ~push_blocked;
    assign m_wr    = (winner == OWN_DATA) ? data_wr    : inst_wr;
    assign m_size  = (winner == OWN_DATA) ? data_size  : inst_size;
    assign m_addr  = (winner == OWN_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (winner == OWN_DATA) ? data_wdata : inst_wdata;

    assign push         = m_req & m_addr_ok;
    assign inst_addr_ok = push & (winner == OWN_INST);
    assign data_addr_ok = push & (winner == OWN_DATA);

    assign inst_data_ok = pop & (head_owner == OWN_INST);
    assign data_data_ok = pop & (head_owner == OWN_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++)
                fifo_owner[i] <= OWN_INST;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            lock       <= 1'b0;
            lock_owner <= OWN_INST;
            starve_cnt <= '0;
            arb_err    <= 1'b0;
        end else begin
            if (push) begin
                fifo_owner[wr_ptr] <= winner;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Hold the presented request until the downstream takes it.
            if (m_req) begin
                lock       <= ~m_addr_ok;
                lock_owner <= winner;
            end

            if (inst_addr_ok || !inst_req)
                starve_cnt <= '0;
            else if (data_addr_ok && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);

            if (m_data_ok && fifo_empty)
                arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Directed testbench for sram_like_arbiter (OUTSTANDING=2, STARVE_MAX=8).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        arb_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(2), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .arb_err(arb_err)
    );

    task set_idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task test_reset();
        reset = 1'b1;
        set_idle();
        m_rdata = 32'h1234_5678;
        @(negedge clk); #1;
        tests++; if (m_req !== 1'b0) begin fails++; $display("FAIL rst_m_req got %b exp 0", m_req); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin fails++; $display("FAIL rst_addr_ok got %b exp 00", {inst_addr_ok, data_addr_ok}); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL rst_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        tests++; if (arb_err !== 1'b0) begin fails++; $display("FAIL rst_arb_err got %b exp 0", arb_err); end
        tests++; if (inst_rdata !== 32'h1234_5678 || data_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rst_rdata got %h/%h exp 12345678", inst_rdata, data_rdata); end
        reset = 1'b0;
        set_idle();
    endtask

    task test_single_inst();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
        #1;
        tests++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL t1_issue got req=%b addr=%h exp 1/bfc00000", m_req, m_addr); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin fails++; $display("FAIL t1_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        set_idle(); m_data_ok = 1; m_rdata = 32'h3C1D_8000;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t1_data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
        tests++; if (inst_rdata !== 32'h3C1D_8000) begin fails++; $display("FAIL t1_rdata got %h exp 3c1d8000", inst_rdata); end
        @(negedge clk); set_idle();
    endtask

    task test_priority();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        m_addr_ok = 1;
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin fails++; $display("FAIL t2_first_grant got %b exp 01", {inst_addr_ok, data_addr_ok}); end
        tests++; if (m_addr !== 32'h8000_0010 || m_wr !== 1'b1 || m_size !== 2'd0 || m_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL t2_mux got addr=%h wr=%b size=%0d wdata=%h exp 80000010/1/0/deadbeef", m_addr, m_wr, m_size, m_wdata); end
        @(negedge clk);
        data_req = 0;
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'hBFC0_0004 || m_wr !== 1'b0) begin fails++; $display("FAIL t2_second_grant got ok=%b addr=%h wr=%b exp 10/bfc00004/0", {inst_addr_ok, data_addr_ok}, m_addr, m_wr); end
        @(negedge clk);
        set_idle(); m_data_ok = 1; m_rdata = 32'h0000_00AA;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL t2_resp1 got %b exp 01", {inst_data_ok, data_data_ok}); end
        tests++; if (data_rdata !== 32'h0000_00AA) begin fails++; $display("FAIL t2_rdata got %h exp 000000aa", data_rdata); end
        @(negedge clk);
        m_rdata = 32'h0000_00BB;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t2_resp2 got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk); set_idle();
    endtask

    task test_lock();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0100; m_addr_ok = 0;
        #1;
        tests++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0100 || inst_addr_ok !== 1'b0) begin fails++; $display("FAIL t3_c1 got req=%b addr=%h ok=%b exp 1/bfc00100/0", m_req, m_addr, inst_addr_ok); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            data_req = 1; data_addr = 32'h8000_0200;
            #1;
            tests++; if (m_addr !== 32'hBFC0_0100 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin fails++; $display("FAIL t3_held_c%0d got addr=%h ok=%b exp bfc00100/00", c, m_addr, {inst_addr_ok, data_addr_ok}); end
        end
        @(negedge clk);
        m_addr_ok = 1;
        #1;
        tests++; if (m_addr !== 32'hBFC0_0100 || {inst_addr_ok, data_addr_ok} !== 2'b10) begin fails++; $display("FAIL t3_accept got addr=%h ok=%b exp bfc00100/10", m_addr, {inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        inst_req = 0;
        #1;
        tests++; if (m_addr !== 32'h8000_0200 || {inst_addr_ok, data_addr_ok} !== 2'b01) begin fails++; $display("FAIL t3_data_after got addr=%h ok=%b exp 80000200/01", m_addr, {inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        set_idle(); m_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t3_resp1 got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL t3_resp2 got %b exp 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); set_idle();
    endtask

    task test_full();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0200; m_addr_ok = 1;
        @(negedge clk);
        inst_req = 0; data_req = 1; data_addr = 32'h8000_0300;
        #1;
        tests++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL t4_second_issue got %b exp 1", data_addr_ok); end
        @(negedge clk);
        data_req = 0; inst_req = 1; inst_addr = 32'hBFC0_0204;
        #1;
        tests++; if (m_req !== 1'b0 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin fails++; $display("FAIL t4_full_block got req=%b ok=%b exp 0/00", m_req, {inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        m_data_ok = 1;
        #1;
        tests++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin fails++; $display("FAIL t4_push_at_full got req=%b ok=%b exp 1/1", m_req, inst_addr_ok); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t4_pop_at_full got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        inst_req = 0;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL t4_resp2 got %b exp 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t4_resp3 got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL t4_drained got %b exp 00", {inst_data_ok, data_data_ok}); end
        set_idle(); reset = 1; #1; reset = 0;
    endtask

    task test_starve();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            inst_req = 1; inst_addr = 32'hBFC0_0300;
            data_req = 1; data_addr = 32'h8000_0400;
            m_addr_ok = 1; m_data_ok = (c > 1);
            #1;
            tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin fails++; $display("FAIL t5_data_grant_%0d got %b exp 01", c, {inst_addr_ok, data_addr_ok}); end
        end
        @(negedge clk);
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'hBFC0_0300) begin fails++; $display("FAIL t5_forced_inst got ok=%b addr=%h exp 10/bfc00300", {inst_addr_ok, data_addr_ok}, m_addr); end
        tests++; if (data_data_ok !== 1'b1) begin fails++; $display("FAIL t5_resp9 got %b exp 1", data_data_ok); end
        @(negedge clk);
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin fails++; $display("FAIL t5_counter_cleared got %b exp 01", {inst_addr_ok, data_addr_ok}); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL t5_resp10 got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        inst_req = 0; data_req = 0;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL t5_resp11 got %b exp 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk); set_idle();
    endtask

    task test_stray();
        @(negedge clk);
        m_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL t6_stray_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        tests++; if (arb_err !== 1'b0) begin fails++; $display("FAIL t6_err_before got %b exp 0", arb_err); end
        @(negedge clk);
        m_data_ok = 0;
        #1;
        tests++; if (arb_err !== 1'b1) begin fails++; $display("FAIL t6_err_set got %b exp 1", arb_err); end
        @(negedge clk);
        inst_req = 1; m_addr_ok = 1;
        #1;
        tests++; if (arb_err !== 1'b1 || inst_addr_ok !== 1'b1) begin fails++; $display("FAIL t6_err_sticky got err=%b ok=%b exp 1/1", arb_err, inst_addr_ok); end
        @(negedge clk);
        set_idle(); reset = 1; #1;
        tests++; if (arb_err !== 1'b0) begin fails++; $display("FAIL t6_err_reset got %b exp 0", arb_err); end
        reset = 0;
        @(negedge clk);
        m_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL t6_preset_resp got %b exp 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        m_data_ok = 0;
        #1;
        tests++; if (arb_err !== 1'b1) begin fails++; $display("FAIL t6_preset_err got %b exp 1", arb_err); end
        set_idle(); reset = 1; #1; reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_priority();
        test_lock();
        test_full();
        test_starve();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
